// File: rtl/jtobj_dmacpy.sv
// Object-table DMA: copies external object RAM into a double-buffered internal
// table once per frame, dropping disabled objects and packing the live ones.
module jtobj_dmacpy #(
    parameter int NOBJ = 256,
    parameter int OBJW = 8,
    parameter int ENB  = 15,
    parameter int EAW  = $clog2(NOBJ*OBJW)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cen,
    input  logic                        dma_en,
    input  logic                        mode8,
    input  logic                        vs,
    output logic [EAW:0]                dma_addr,
    input  logic [15:0]                 dma_data,
    output logic [EAW:0]                wr_addr,
    output logic [15:0]                 wr_data,
    output logic                        wr_we,
    output logic                        rd_bank,
    output logic [$clog2(NOBJ+1)-1:0]   obj_cnt,
    output logic                        busy,
    output logic                        done
);
    localparam int OW = $clog2(NOBJ);
    localparam int WW = $clog2(OBJW);
    localparam int CW = $clog2(NOBJ+1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t          state, state_nx;
    logic [OW-1:0]   obj;
    logic [WW-1:0]   word;
    logic            bsel, m8, vs_l;
    logic [7:0]      hi_byte;
    logic [EAW-1:0]  ptr;
    logic [CW-1:0]   live;
    logic [15:0]     word_asm;
    logic            asm_ok, skip, last_word, last_obj, obj_end, trig;

    // Byte 0 of each word is the high byte in byte-wide mode
    assign dma_addr = {obj, word, m8 & bsel};

    always_comb begin
        word_asm  = m8 ? {hi_byte, dma_data[7:0]} : dma_data;
        asm_ok    = !m8 || bsel;
        skip      = (word == '0) && !word_asm[ENB];
        last_word = word == WW'(OBJW-1);
        last_obj  = obj == OW'(NOBJ-1);
        obj_end   = skip || last_word;
        trig      = vs && !vs_l && dma_en;
        state_nx  = state;
        if (cen) begin
            case (state)
                IDLE: if (trig) state_nx = ADDR;
                ADDR: state_nx = dma_en ? DATA : IDLE;
                DATA: begin
                    if (!dma_en)                            state_nx = IDLE;
                    else if (asm_ok && obj_end && last_obj) state_nx = DONE;
                    else                                    state_nx = ADDR;
                end
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj     <= '0;
            word    <= '0;
            bsel    <= 1'b0;
            m8      <= 1'b0;
            vs_l    <= 1'b1;
            hi_byte <= '0;
            ptr     <= '0;
            live    <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_we   <= 1'b0;
            rd_bank <= 1'b0;
            obj_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_we <= 1'b0;
            done  <= 1'b0;
            if (cen) begin
                // vs history advances even while busy, so edges are never queued
                vs_l <= vs;
                case (state)
                    IDLE: if (trig) begin
                        obj  <= '0;
                        word <= '0;
                        bsel <= 1'b0;
                        ptr  <= '0;
                        live <= '0;
                        m8   <= mode8;
                        busy <= 1'b1;
                    end
                    ADDR: if (!dma_en) busy <= 1'b0;
                    DATA: begin
                        if (!dma_en) begin
                            busy <= 1'b0;
                        end else if (!asm_ok) begin
                            hi_byte <= dma_data[7:0];
                            bsel    <= 1'b1;
                        end else begin
                            bsel <= 1'b0;
                            if (!skip) begin
                                wr_we   <= 1'b1;
                                wr_addr <= {~rd_bank, ptr};
                                wr_data <= word_asm;
                                ptr     <= ptr + EAW'(1);
                            end
                            if (obj_end) begin
                                word <= '0;
                                obj  <= obj + OW'(1);
                                if (!skip) live <= live + CW'(1);
                            end else begin
                                word <= word + WW'(1);
                            end
                        end
                    end
                    DONE: begin
                        rd_bank <= ~rd_bank;
                        obj_cnt <= live;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/jtobj_dmacpy.md
# jtobj_dmacpy

Parametrised object-table DMA engine for the Konami 05324x sprite family. It copies an external object RAM into a double-buffered internal object table once per frame. Disabled objects are dropped and the enabled ones packed contiguously, so the scanner walks only live entries. It supports 16-bit and 8-bit (byte-wide) external buses, and the scanner reads the bank that is not currently being written.

## Interface
Parameters:
- NOBJ, 256, number of object slots in external RAM (power of two)
- OBJW, 8, 16-bit words per object (power of two, ≥2)
- ENB, 15, bit of word 0 that marks an object enabled
- EAW, $clog2(NOBJ*OBJW), word-index width (derived, do not override)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- cen  input  1  clock enable (pxl2_cen); every state change is gated by it
- dma_en  input  1  level enable; low aborts a transfer
- mode8  input  1  1 = byte-wide external bus
- vs  input  1  vertical sync; a rising edge triggers a transfer
- dma_addr  output  EAW+1  external byte address; bit 0 is always 0 in 16-bit mode
- dma_data  input  16  external read data; only [7:0] is used in mode8
- wr_addr  output  EAW+1  internal table address: {bank, packed word index}
- wr_data  output  16  internal table write data
- wr_we  output  1  one-clk write strobe
- rd_bank  output  1  bank the scanner reads (the opposite of the write bank)
- obj_cnt  output  $clog2(NOBJ+1)  enabled objects in rd_bank
- busy  output  1  transfer in progress
- done  output  1  one-clk pulse on a completed transfer

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - vs rising edge (edge-detected on cen ticks) with dma_en=1 → ADDR.
  - On entry, src object=0, word=0, packed pointer=0, live count=0.
- ADDR (one cen tick):
  - dma_addr = byte address of (object*OBJW + word).
  - In mode8 the byte address advances through high byte then low byte.
  - Next state is DATA.
- DATA (one cen tick):
  - Sample dma_data.
  - mode8 first byte: hold it as the high byte, step to the low byte, return to ADDR.
- Word assembled (16-bit, or second byte in mode8):
  - If word=0 and data[ENB]=0: no write; advance to the next object, word=0.
  - Otherwise: wr_addr={~rd_bank, packed pointer}, wr_data=word, wr_we=1 for one clk; packed pointer +1.
  - If word=OBJW-1: live count +1, next object.
- After the last object (NOBJ-1) → DONE.
- DONE: rd_bank toggles, obj_cnt ← live count, done=1 for one clk, → IDLE.
- dma_en low on any cen tick in ADDR/DATA:
  - → IDLE immediately, no toggle, no done, obj_cnt unchanged.
  - Words already written to the hidden bank remain but are never exposed.
- vs edges while busy are ignored. Triggers are not queued.
- Stale words past the packed pointer in the hidden bank are not cleared. The scanner relies on obj_cnt.
- mode8 and dma_en are sampled at trigger, except for the abort above. A mid-transfer change of mode8 has no effect until the next transfer.
- All objects disabled: zero writes, still toggles, obj_cnt=0.

## Timing
- Reset values: state IDLE, rd_bank=0, obj_cnt=0, busy=0, done=0, wr_we=0, dma_addr=0, wr_addr=0, wr_data=0.
- busy rises on the cen tick that leaves IDLE. It falls on the cen tick that enters IDLE from DONE or abort.
- Cost per word read: 2 cen ticks in 16-bit mode, 4 cen ticks in mode8.
- Cost per object: a skipped object costs one word read; an enabled object costs OBJW reads.
- Full transfer, 16-bit, all enabled: 2*NOBJ*OBJW cen ticks, plus 1 for DONE.
- Full transfer, all disabled: 2*NOBJ+1 cen ticks.
- External read latency is one cen tick: dma_data must be valid at the DATA tick that follows the ADDR tick.
- wr_we is asserted in the clk cycle after the DATA cen tick. It is never asserted on consecutive clks when cen has a duty ≤50%.
- The rd_bank toggle and the obj_cnt update take effect in the same clk as done.
- Async reset mid-transfer returns all outputs to reset values at once. The next transfer needs a fresh vs edge.

## Test plan
- NOBJ=4, OBJW=2, 16-bit, cen every clk; ext words {8001,1111, 0002,2222, 8003,3333, 0004,4444}; vs edge.
  - Required: writes {8001,1111,8003,3333} at bank1 addresses 0..3.
  - Required: then rd_bank=1, obj_cnt=2, done pulse; busy high for 2*(2+1+2+1)+1=13 cen ticks.
- Same table with mode8; bytes supplied high/low in order.
  - Required: identical writes and obj_cnt=2.
  - Required: dma_addr sequence starts 0,1,2,3 then jumps to 4 (object 1, word 0); bit 0 toggles per byte.
- All word0[15]=0.
  - Required: no wr_we, done after 2*4+1 cen ticks, rd_bank toggles, obj_cnt=0.
- Drop dma_en during the object 2 read.
  - Required: busy falls on that cen tick, no done, rd_bank and obj_cnt unchanged.
  - Required: the next vs edge restarts from object 0.
- A second vs edge during a transfer is ignored (exactly one done). Then the back-to-back frame writes bank0 and rd_bank returns to 0.
- Assert rst_n low mid-DATA.
  - Required: all outputs at reset values immediately, with no clk edge needed.
  - Required: state stays IDLE until a new vs edge.
